enc_formatter: RTL and testbench



---
 rtl/enc_formatter_pkg.sv | 29 ++
 rtl/enc_formatter_counter.sv | 29 ++
 rtl/enc_formatter.sv | 169 ++++++++++++++++
 tb/tb_enc_formatter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/enc_formatter_pkg.sv
// Shared encoder header: symbol geometry, codeword lengths, derived beat
// counts and the phase encoding understood by the parity processor.
package enc_formatter_pkg;

   localparam int EGF_ORDER   = 8;
   localparam int RS_MES_LEN  = 239;
   localparam int RS_PAR_LEN  = 16;
   localparam int ENC_SYM_NUM = 4;

   localparam int MES_BEATS = (RS_MES_LEN + ENC_SYM_NUM - 1) / ENC_SYM_NUM;
   localparam int PAR_BEATS = (RS_PAR_LEN + ENC_SYM_NUM - 1) / ENC_SYM_NUM;

   localparam int DATA_W      = ENC_SYM_NUM * EGF_ORDER;
   localparam int FOR_PHASE_W = 3;

   // A single-beat message still needs a 1-bit counter to exist
   localparam int BEAT_W  = (MES_BEATS > 1) ? $clog2(MES_BEATS) : 1;
   localparam int DRAIN_W = $clog2(PAR_BEATS + 1);

   // FOR_STA tells the processor to hold its register for a stalled cycle
   typedef enum logic [FOR_PHASE_W-1:0] {
      FOR_IDL = 3'd0,
      FOR_FIR = 3'd1,
      FOR_NOR = 3'd2,
      FOR_LAS = 3'd3,
      FOR_STA = 3'd4
   } for_phase_t;

endpackage

// File: rtl/enc_formatter_counter.sv
// Saturating terminal-count counter. clr restarts the count; clr together
// with inc restarts it at one so the first counted event is not lost.
module enc_for_counter #(
   parameter int WIDTH = 4,
   parameter int TERM  = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   logic at_term;

   assign at_term = (cnt == WIDTH'(TERM));

   // Count register; holds at TERM rather than wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= inc ? WIDTH'(1) : '0;
      end else if (inc && !at_term) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

endmodule

// File: rtl/enc_formatter.sv
// Message framer in front of the parity processor: turns accepted beats into
// FIR/NOR/LAS phases, inserts STA on source stalls, appends a fixed IDL drain
// for parity shift-out and flags misplaced in_last.
module enc_formatter
   import enc_formatter_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   in_last,
   output logic [FOR_PHASE_W-1:0] for_phase,
   output logic [DATA_W-1:0]      for_data,
   output logic                   for_drain,
   output logic                   for_err
);

   // A message length that is a whole number of beats is not supported
   generate
      if ((RS_MES_LEN % ENC_SYM_NUM) == 0) begin : g_bad_mes_len
         $error("enc_formatter: RS_MES_LEN must not be a multiple of ENC_SYM_NUM");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDL = 2'd0,
      S_MES = 2'd1,
      S_DRN = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [FOR_PHASE_W-1:0] phase_next;
   logic [DATA_W-1:0]      data_next;
   logic                   drain_next;
   logic                   err_next;
   logic                   accept;

   logic                   beat_clr;
   logic                   beat_inc;
   logic                   drain_clr;
   logic                   drain_inc;
   logic [BEAT_W-1:0]      beat_cnt;
   logic [DRAIN_W-1:0]     drain_cnt;
   logic                   beat_last;
   logic                   drain_done;

   assign in_ready   = (state != S_DRN);
   assign accept     = in_valid && in_ready;
   assign beat_last  = (beat_cnt == BEAT_W'(MES_BEATS - 1));
   assign drain_done = (drain_cnt == DRAIN_W'(PAR_BEATS));

   enc_for_counter #(
      .WIDTH (BEAT_W),
      .TERM  (MES_BEATS - 1)
   ) u_beat_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (beat_clr),
      .inc   (beat_inc),
      .cnt   (beat_cnt)
   );

   enc_for_counter #(
      .WIDTH (DRAIN_W),
      .TERM  (PAR_BEATS)
   ) u_drain_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (drain_clr),
      .inc   (drain_inc),
      .cnt   (drain_cnt)
   );

   // Symbols pass through only on accepted beats; every other cycle carries zero
   genvar gi;
   generate
      for (gi = 0; gi < ENC_SYM_NUM; gi++) begin : g_lane
         assign data_next[gi*EGF_ORDER +: EGF_ORDER] =
            accept ? in_data[gi*EGF_ORDER +: EGF_ORDER] : '0;
      end
   endgenerate

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDL;
      end else begin
         state <= state_next;
      end
   end

   // Next-state, next-phase and counter control
   always_comb begin
      state_next = state;
      phase_next = FOR_IDL;
      drain_next = 1'b0;
      err_next   = 1'b0;
      beat_clr   = 1'b0;
      beat_inc   = 1'b0;
      drain_clr  = 1'b0;
      drain_inc  = 1'b0;
      case (state)
         S_IDL: begin
            if (accept) begin
               phase_next = FOR_FIR;
               beat_clr   = 1'b1;
               beat_inc   = 1'b1;
               drain_clr  = 1'b1;
               if (in_last || (MES_BEATS == 1)) begin
                  err_next   = in_last;
                  state_next = S_DRN;
               end else begin
                  state_next = S_MES;
               end
            end
         end
         S_MES: begin
            if (accept) begin
               if (beat_last) begin
                  // The final beat closes the message whether or not in_last is set
                  phase_next = FOR_LAS;
                  err_next   = !in_last;
                  state_next = S_DRN;
               end else if (in_last) begin
                  phase_next = FOR_LAS;
                  err_next   = 1'b1;
                  state_next = S_DRN;
               end else begin
                  phase_next = FOR_NOR;
                  beat_inc   = 1'b1;
               end
            end else begin
               phase_next = FOR_STA;
            end
         end
         S_DRN: begin
            // One extra DRN cycle after the drain pulses keeps in_ready low
            // until the last for_drain cycle has been presented
            if (drain_done) begin
               state_next = S_IDL;
            end else begin
               drain_next = 1'b1;
               drain_inc  = 1'b1;
            end
         end
         default: begin
            state_next = S_IDL;
         end
      endcase
   end

   // Registered outputs to the processor
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for_phase <= FOR_IDL;
         for_data  <= '0;
         for_drain <= 1'b0;
         for_err   <= 1'b0;
      end else begin
         for_phase <= phase_next;
         for_data  <= data_next;
         for_drain <= drain_next;
         for_err   <= err_next;
      end
   end

endmodule

// File: tb/tb_enc_formatter.sv
// Directed bench for enc_formatter with an expected-output scoreboard.
module tb_enc_formatter;
   import enc_formatter_pkg::*;

   logic                   clk;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_W-1:0]      in_data;
   logic                   in_last;
   logic [FOR_PHASE_W-1:0] for_phase;
   logic [DATA_W-1:0]      for_data;
   logic                   for_drain;
   logic                   for_err;

   typedef struct {
      logic [2:0]  phase;
      logic [31:0] data;
      logic        err;
      logic        drain;
   } exp_t;

   exp_t sb[$];
   int   total;
   int   passed;

   enc_formatter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .for_phase (for_phase),
      .for_data  (for_data),
      .for_drain (for_drain),
      .for_err   (for_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no completion, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: check in_ready, drive inputs, queue expected outputs, then
   // pop and compare just after the edge
   task automatic cyc(input logic v, input logic [31:0] d, input logic l,
                      input logic eready, input logic [2:0] ephase,
                      input logic [31:0] edata, input logic eerr, input logic edrain);
      exp_t e;
      exp_t got;
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 32'(eready));
      in_valid = v;
      in_data  = d;
      in_last  = l;
      e.phase = ephase; e.data = edata; e.err = eerr; e.drain = edrain;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk("for_phase", 32'(for_phase), 32'(got.phase));
      chk("for_data",  for_data,       got.data);
      chk("for_err",   32'(for_err),   32'(got.err));
      chk("for_drain", 32'(for_drain), 32'(got.drain));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_phase"}, 32'(for_phase), 32'(FOR_IDL));
      chk({tag, "_data"},  for_data,       32'h0);
      chk({tag, "_drain"}, 32'(for_drain), 32'h0);
      chk({tag, "_err"},   32'(for_err),   32'h0);
      chk({tag, "_ready"}, 32'(in_ready),  32'h1);
   endtask

   // last_at: beat carrying in_last (0 = never); stall inserted after beat
   // stall_after; offer keeps in_valid high through the drain; rst_at_drain2
   // pulls reset during the second drain cycle
   task automatic send_msg(input int last_at, input int stall_after, input int stall_len,
                           input logic offer, input logic rst_at_drain2);
      logic [31:0] d;
      logic        l;
      logic        fin;
      logic        e;
      logic [2:0]  ph;
      for (int i = 1; i <= MES_BEATS; i++) begin
         d   = $urandom;
         if (i == 1) d = d & 32'h00FF_FFFF;
         l   = (i == last_at);
         fin = l || (i == MES_BEATS);
         e   = (l && i != MES_BEATS) || (i == MES_BEATS && !l);
         ph  = (i == 1) ? 3'(FOR_FIR) : (fin ? 3'(FOR_LAS) : 3'(FOR_NOR));
         cyc(1'b1, d, l, 1'b1, ph, d, e, 1'b0);
         $display("beat %0d phase %0d data %08h last %0b err %0b", i, for_phase, for_data, l, for_err);
         if (fin) break;
         if (i == stall_after) begin
            for (int s = 0; s < stall_len; s++) begin
               cyc(1'b0, 32'h0, 1'b0, 1'b1, 3'(FOR_STA), 32'h0, 1'b0, 1'b0);
               $display("stall %0d phase %0d", s, for_phase);
            end
         end
      end
      for (int k = 0; k < PAR_BEATS; k++) begin
         if (rst_at_drain2 && k == 2) begin
            @(negedge clk);
            rst_n    = 1'b0;
            in_valid = 1'b0;
            in_last  = 1'b0;
            #1;
            check_reset_values("async_rst");
            $display("reset during drain: phase %0d drain %0b ready %0b", for_phase, for_drain, in_ready);
            #3;
            rst_n = 1'b1;
            return;
         end
         cyc(offer, $urandom, 1'b0, 1'b0, 3'(FOR_IDL), 32'h0, 1'b0, 1'b1);
         $display("drain %0d phase %0d drain %0b", k, for_phase, for_drain);
      end
      cyc(offer, $urandom, 1'b0, 1'b0, 3'(FOR_IDL), 32'h0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 3'(FOR_IDL), 32'h0, 1'b0, 1'b0);
      $display("message done, in_ready %0b", in_ready);
   endtask

   initial begin
      total    = 0;
      passed   = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Idle with no valid
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 32'h0, 1'b0, 1'b1, 3'(FOR_IDL), 32'h0, 1'b0, 1'b0);
         $display("idle %0d phase %0d ready %0b", i, for_phase, in_ready);
      end

      // Back-to-back message with correct in_last
      send_msg(MES_BEATS, 0, 0, 1'b0, 1'b0);
      // Same message with a 3-cycle stall after beat 10
      send_msg(MES_BEATS, 10, 3, 1'b0, 1'b0);
      // Early in_last on beat 30, then a clean message must start with FIR
      send_msg(30, 0, 0, 1'b0, 1'b0);
      // Beat 60 without in_last; a beat offered during drain is refused
      send_msg(0, 0, 0, 1'b1, 1'b0);
      // Reset during drain cycle 2, then a fresh message
      send_msg(MES_BEATS, 0, 0, 1'b0, 1'b1);
      send_msg(MES_BEATS, 5, 2, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
